// File: rtl/mdu_pkg.sv
// Shared types and decode helpers for the RV32M multiply/divide unit.
package mdu_pkg;

  localparam logic [6:0] RV32M_FUN7 = 7'b0000001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } mdu_state_e;

  function automatic logic op_is_div(input mdu_op_e op);
    return (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU});
  endfunction

  function automatic logic op_is_rem(input mdu_op_e op);
    return (op inside {OP_REM, OP_REMU});
  endfunction

  function automatic logic op_rs1_signed(input mdu_op_e op);
    return (op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  endfunction

  function automatic logic op_rs2_signed(input mdu_op_e op);
    return (op inside {OP_MULH, OP_DIV, OP_REM});
  endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// Execute-stage handshake between the pipeline and the multiply/divide unit.
interface mdu_sequencer_if #(parameter int XLEN = 32) ();

  logic            start_i;
  logic [2:0]      fun3_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            flush_i;
  logic            stall_o;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, fun3_i, rs1_i, rs2_i, flush_i,
    input  stall_o, busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, fun3_i, rs1_i, rs2_i, flush_i,
    output stall_o, busy_o, done_o, result_o
  );

endinterface

// File: rtl/mdu_div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift the next
// dividend bit into the partial remainder, subtract when it fits.
module mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            fits;

  // trial subtraction; remainder < divisor keeps the difference within XLEN bits
  always_comb begin
    shifted = {rem_i, quo_i[XLEN-1]};
    diff    = shifted[XLEN-1:0] - divisor_i;
    fits    = (shifted >= {1'b0, divisor_i});
    if (fits) begin
      rem_o = diff;
    end else begin
      rem_o = shifted[XLEN-1:0];
    end
    quo_o = {quo_i[XLEN-2:0], fits};
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide sequencer (IDLE -> CALC -> DONE).
// Optional build macro: MDU_FAST_MUL_EN selects a single-cycle multiplier
// for MUL/MULH/MULHSU/MULHU; divides always iterate.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 32
) (
  input logic           clk,
  input logic           rst,
  mdu_sequencer_if.slave bus
);

  localparam int              CNT_W    = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e       state, state_next;
  logic [CNT_W-1:0] cnt;
  mdu_op_e          op;
  logic             neg;
  logic [XLEN-1:0]  mag;
  logic [XLEN-1:0]  hi, lo;
  logic             busy, done;
  logic [XLEN-1:0]  result;

  mdu_op_e          req_op;
  logic             rs1_neg, rs2_neg;
  logic [XLEN-1:0]  rs1_mag, rs2_mag;
  logic             accept, div_zero, div_ovf, special, fast_sel;
  logic [XLEN-1:0]  special_res;

  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_hi_next, mul_lo_next;
  logic [XLEN-1:0]   div_rem_next, div_quo_next;
  logic [XLEN-1:0]   step_hi, step_lo;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   final_res;

  assign req_op  = mdu_op_e'(bus.fun3_i);
  assign rs1_neg = op_rs1_signed(req_op) & bus.rs1_i[XLEN-1];
  assign rs2_neg = op_rs2_signed(req_op) & bus.rs2_i[XLEN-1];
  assign rs1_mag = rs1_neg ? (~bus.rs1_i + {{(XLEN-1){1'b0}}, 1'b1}) : bus.rs1_i;
  assign rs2_mag = rs2_neg ? (~bus.rs2_i + {{(XLEN-1){1'b0}}, 1'b1}) : bus.rs2_i;
  assign accept  = (state == ST_IDLE) & bus.start_i & ~bus.flush_i;

  // corner cases resolved at issue without iterating
  always_comb begin
    div_zero    = op_is_div(req_op) && (bus.rs2_i == {XLEN{1'b0}});
    div_ovf     = (req_op inside {OP_DIV, OP_REM}) && (bus.rs1_i == INT_MIN) &&
                  (bus.rs2_i == {XLEN{1'b1}});
    special     = div_zero | div_ovf;
    special_res = {XLEN{1'b0}};
    if (div_zero) begin
      special_res = op_is_rem(req_op) ? bus.rs1_i : {XLEN{1'b1}};
    end else if (div_ovf) begin
      special_res = op_is_rem(req_op) ? {XLEN{1'b0}} : INT_MIN;
    end else begin
      special_res = {XLEN{1'b0}};
    end
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  logic [XLEN-1:0]   fast_res;

  // single-cycle signed/unsigned multiply on magnitudes
  always_comb begin
    fast_prod = {{XLEN{1'b0}}, rs1_mag} * {{XLEN{1'b0}}, rs2_mag};
    if (rs1_neg ^ rs2_neg) begin
      fast_prod = ~fast_prod + {{(2*XLEN-1){1'b0}}, 1'b1};
    end else begin
      fast_prod = fast_prod;
    end
    if (req_op == OP_MUL) begin
      fast_res = fast_prod[XLEN-1:0];
    end else begin
      fast_res = fast_prod[2*XLEN-1:XLEN];
    end
  end

  assign fast_sel = ~op_is_div(req_op);
`else
  assign fast_sel = 1'b0;
`endif

  // shift-add multiply iteration: hi accumulates, lo holds the multiplier
  always_comb begin
    mul_sum     = {1'b0, hi} + (lo[0] ? {1'b0, mag} : {(XLEN+1){1'b0}});
    mul_hi_next = mul_sum[XLEN:1];
    mul_lo_next = {mul_sum[0], lo[XLEN-1:1]};
  end

  mdu_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_i     (hi),
    .quo_i     (lo),
    .divisor_i (mag),
    .rem_o     (div_rem_next),
    .quo_o     (div_quo_next)
  );

  // pick the active iteration and form the final signed result from it
  always_comb begin
    if (op_is_div(op)) begin
      step_hi = div_rem_next;
      step_lo = div_quo_next;
    end else begin
      step_hi = mul_hi_next;
      step_lo = mul_lo_next;
    end
    prod   = {step_hi, step_lo};
    prod_s = neg ? (~prod + {{(2*XLEN-1){1'b0}}, 1'b1}) : prod;
    case (op)
      OP_MUL:                       final_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_res = neg ? (~step_lo + {{(XLEN-1){1'b0}}, 1'b1}) : step_lo;
      OP_REM, OP_REMU:              final_res = neg ? (~step_hi + {{(XLEN-1){1'b0}}, 1'b1}) : step_hi;
      default:                      final_res = {XLEN{1'b0}};
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state logic; flush overrides everything
  always_comb begin
    state_next = state;
    if (bus.flush_i) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state_next = (special | fast_sel) ? ST_DONE : ST_CALC;
          end else begin
            state_next = ST_IDLE;
          end
        end
        ST_CALC: begin
          if (cnt == CNT_LAST) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_CALC;
          end
        end
        ST_DONE: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // operand latch, iteration datapath, counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= {CNT_W{1'b0}};
      op     <= OP_MUL;
      neg    <= 1'b0;
      mag    <= {XLEN{1'b0}};
      hi     <= {XLEN{1'b0}};
      lo     <= {XLEN{1'b0}};
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= {XLEN{1'b0}};
    end else begin
      done <= 1'b0;
      busy <= (state_next != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op  <= req_op;
            cnt <= {CNT_W{1'b0}};
            neg <= op_is_rem(req_op) ? rs1_neg : (rs1_neg ^ rs2_neg);
            if (special) begin
              result <= special_res;
              done   <= 1'b1;
            end
`ifdef MDU_FAST_MUL_EN
            else if (fast_sel) begin
              result <= fast_res;
              done   <= 1'b1;
            end
`endif
            else if (op_is_div(req_op)) begin
              mag <= rs2_mag;
              hi  <= {XLEN{1'b0}};
              lo  <= rs1_mag;
            end else begin
              mag <= rs1_mag;
              hi  <= {XLEN{1'b0}};
              lo  <= rs2_mag;
            end
          end
        end
        ST_CALC: begin
          if (bus.flush_i) begin
            cnt <= {CNT_W{1'b0}};
          end else begin
            hi  <= step_hi;
            lo  <= step_lo;
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt == CNT_LAST) begin
              result <= final_res;
              done   <= 1'b1;
              cnt    <= {CNT_W{1'b0}};
            end
          end
        end
        default: cnt <= {CNT_W{1'b0}};
      endcase
    end
  end

  assign bus.stall_o  = ~rst & ((bus.start_i & (state == ST_IDLE)) | (state == ST_CALC));
  assign bus.busy_o   = busy;
  assign bus.done_o   = done;
  assign bus.result_o = result;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: hand-computed RV32M results, latency,
// stall profile, flush and reset behaviour.
module tb_mdu_sequencer;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  mdu_sequencer_if #(.XLEN(32)) bus ();

  mdu_sequencer #(.XLEN(32), .MUL_CYCLES(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, required finish before 400000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_start(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bus.start_i = 1'b1;
    bus.fun3_i  = f3;
    bus.rs1_i   = a;
    bus.rs2_i   = b;
  endtask

  // Called in cycle 0 (start already driven); hold = cycles start stays high.
  task automatic wait_done(input string tag, input logic [31:0] exp_res,
                           input int exp_lat, input int hold);
    int lat;
    int stall_bad;
    lat       = 0;
    stall_bad = 0;
    #1;
    chk({tag, "_stall0"}, {63'd0, bus.stall_o}, 64'd1);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        chk({tag, "_busy1"}, {63'd0, bus.busy_o}, 64'd1);
        if (hold > 1) begin
          bus.fun3_i = 3'b101;
          bus.rs2_i  = 32'd0;
        end
      end
      if (k == hold) bus.start_i = 1'b0;
      if (bus.stall_o !== (k < exp_lat)) stall_bad++;
      if (bus.done_o === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, {32'd0, bus.result_o}, {32'd0, exp_res});
    chk({tag, "_stall"}, stall_bad, 64'd0);
    @(posedge clk);
    #1;
    chk({tag, "_post"}, {62'd0, bus.done_o, bus.busy_o}, 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    @(negedge clk);
    drive_start(f3, a, b);
    wait_done(tag, exp_res, exp_lat, 1);
  endtask

  initial begin
    int seen_done;
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.fun3_i  = 3'b000;
    bus.rs1_i   = 32'd0;
    bus.rs2_i   = 32'd0;

    // reset state, and stall suppressed while reset is high
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {31'd0, bus.done_o, bus.busy_o, bus.result_o}, 64'd0);
    bus.start_i = 1'b1;
    #1;
    chk("rst_stall", {63'd0, bus.stall_o}, 64'd0);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // multiplies
    run_op("mul_7xm3",   3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    run_op("mulh_min2",  3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
    run_op("mulhu_max2", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    run_op("mulhsu_m1",  3'b010, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, MUL_LAT);
    run_op("mulh_m1m1",  3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT);
    run_op("mul_3x4",    3'b000, 32'd3,        32'd4,        32'd12,        MUL_LAT);

    // divide corner cases (one cycle)
    run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    run_op("divu_z",     3'b101, 32'd5,        32'd0,        32'hFFFF_FFFF, 1);
    run_op("rem_z",      3'b110, 32'd5,        32'd0,        32'd5,         1);

    // iterative divides
    run_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33);
    run_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33);
    run_op("div_7_m2",   3'b100, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_op("rem_7_m2",   3'b110, 32'd7,        32'hFFFF_FFFE, 32'd1,         33);
    run_op("divu_100_7", 3'b101, 32'd100,      32'd7,        32'd14,        33);
    run_op("remu_100_7", 3'b111, 32'd100,      32'd7,        32'd2,         33);

    // start held high (with a divide-by-zero request) while busy is ignored
    @(negedge clk);
    drive_start(3'b100, 32'hFFFF_FFF9, 32'd2);
    wait_done("ign_start", 32'hFFFF_FFFD, 33, 10);

    // flush in cycle 10 aborts, new start accepted in cycle 11
    @(negedge clk);
    drive_start(3'b101, 32'd1000, 32'd3);
    seen_done = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) bus.start_i = 1'b0;
      if (bus.done_o === 1'b1) seen_done++;
    end
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    if (bus.done_o === 1'b1) seen_done++;
    chk("flush_nodone", seen_done, 64'd0);
    chk("flush_idle", {62'd0, bus.busy_o, bus.stall_o}, 64'd0);
    drive_start(3'b101, 32'd100, 32'd7);
    wait_done("flush_restart", 32'd14, 33, 1);

    // result held while idle, reset at cycle 5 clears everything
    @(negedge clk);
    drive_start(3'b100, 32'hFFFF_FFF9, 32'd2);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) bus.start_i = 1'b0;
    end
    chk("hold_res", {32'd0, bus.result_o}, 64'd14);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid", {30'd0, bus.done_o, bus.busy_o, bus.stall_o, bus.result_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", 3'b000, 32'd3, 32'd4, 32'd12, MUL_LAT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter MUL_CYCLES, default 32, iterative multiply steps (must equal XLEN).
REQ-003 clk  input  1  rising-edge clock, sole clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start_i  input  1  request; high in the cycle an RV32M op (opcode 0110011, fun7 0000001) sits in execute.
REQ-006 fun3_i  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 rs1_i, rs2_i  input  XLEN  operands (readData1/readData2).
REQ-008 flush_i  input  1  pipeline flush; aborts operation in flight.
REQ-009 stall_o  output  1  freezes PC and fetch/decode register while the unit owns execute.
REQ-010 busy_o  output  1  registered; high whenever state != IDLE.
REQ-011 done_o  output  1  one-cycle result-valid pulse.
REQ-012 result_o  output  XLEN  registered result; held until next done_o.

Function
REQ-013 FSM states SHALL be IDLE, CALC, DONE.
REQ-014 IDLE: start_i high and flush_i low SHALL latch fun3_i, operands, and sign flags; next state CALC, or DONE for special cases (REQ-019/020).
REQ-015 CALC SHALL run exactly MUL_CYCLES steps (shift-add multiply / restoring divide on magnitudes), step counter 0..MUL_CYCLES-1, then go to DONE.
REQ-016 DONE SHALL assert done_o, load result_o, and return to IDLE next cycle.
REQ-017 Normal latency: done_o high exactly 33 cycles after the edge sampling start_i.
REQ-018 stall_o = (start_i & state==IDLE) | (state==CALC) (combinational); low in DONE so the pipeline advances with result.
REQ-019 Divisor zero: DIV/DIVU quotient = all-ones, REM/REMU remainder = rs1; done_o 1 cycle after start.
REQ-020 Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, DIV/REM): quotient 0x80000000, remainder 0; done_o 1 cycle after start.
REQ-021 Signs: MULH both signed, MULHSU rs1 signed/rs2 unsigned, MULHU none; quotient negated iff operand signs differ; remainder takes dividend sign.
REQ-022 MUL returns product[31:0]; MULH* return product[63:32].
REQ-023 start_i while state != IDLE SHALL be ignored.
REQ-024 flush_i in any state SHALL force IDLE next cycle with no done_o; flush_i beats start_i in the same cycle.

Reset
REQ-025 rst high at clock edge SHALL force IDLE, counter 0, result_o 0, done_o 0, busy_o 0, regardless of operation in flight; stall_o 0 while rst high.

Configuration
REQ-026 Macro MDU_FAST_MUL_EN defined: MUL/MULH/MULHSU/MULHU SHALL compute via single-cycle 64-bit multiply, IDLE->DONE, done_o 1 cycle after start; divides unchanged.
REQ-027 MDU_FAST_MUL_EN undefined: all multiplies SHALL use the iterative CALC path (REQ-017 latency).

Structure
REQ-028 Package mdu_pkg SHALL hold the fun3 op enum, FSM state enum, and constant RV32M_FUN7 = 7'b0000001.
REQ-029 Restoring-divide step datapath SHALL be sub-module mdu_div_step (combinational one-iteration remainder/quotient update); the FSM and counter stay in mdu_sequencer.

Verification
REQ-030 MUL 7 x 0xFFFFFFFD -> done_o at cycle 33, result 0xFFFFFFEB; stall_o high cycles 0..32.
REQ-031 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-032 DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at cycle 1; DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
REQ-033 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF, both at cycle 33.
REQ-034 Start DIVU, flush_i at cycle 10 -> no done_o, IDLE at cycle 11, new start accepted at cycle 11; rst at cycle 5 of another op -> all outputs 0 next cycle.
REQ-035 With MDU_FAST_MUL_EN: MUL 3 x 4 -> 12 with done_o at cycle 1.
